// File: rtl/sevseg_scan_counter.sv
// Seven-segment controller: BCD up/down counter, rotating-segment animation digit and
// a time-multiplexed common-anode scan driver with optional leading-zero blanking.
module sevseg_scan_counter #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned ANIM_DIV   = 25_000_000,
  parameter int unsigned SCAN_DIV   = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          hold,
  input  logic                          dir,
  input  logic                          load,
  input  logic [4*(NUM_DIGITS-1)-1:0]   load_val,
  input  logic                          blank_lz,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          dp,
  output logic [4*(NUM_DIGITS-1)-1:0]   count_bcd,
  output logic                          wrap
);

  localparam int unsigned NumBcd = NUM_DIGITS - 1;
  localparam int unsigned BcdW   = 4 * NumBcd;
  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned AnimW  = $clog2(ANIM_DIV);
  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [AnimW-1:0] AnimMax = AnimW'(ANIM_DIV - 1);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NUM_DIGITS - 1);

  logic [TickW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [AnimW-1:0]      anim_cnt_q, anim_cnt_d;
  logic [ScanW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [BcdW-1:0]       count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [5:0]            anim_q, anim_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic            active, tick, step, scan_wrap;
  logic [BcdW-1:0] load_clean, inc_val, dec_val;
  logic            carry, borrow;
  logic [NumBcd-1:0] blank;
  logic            zero_above;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Prescalers share the run/hold gate; a load restarts the tick period.
  always_comb begin
    active     = run & ~hold;
    tick       = active & (tick_cnt_q == TickMax);
    step       = active & (anim_cnt_q == AnimMax);
    tick_cnt_d = tick_cnt_q;
    anim_cnt_d = anim_cnt_q;
    if (load) begin
      tick_cnt_d = '0;
    end else if (active) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    end
    if (active) begin
      anim_cnt_d = step ? '0 : anim_cnt_q + AnimW'(1);
    end
  end

  always_comb begin
    load_clean = '0;
    for (int i = 0; i < int'(NumBcd); i++) begin
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  // Ripple BCD increment and decrement; carry/borrow surviving the top digit means wrap.
  always_comb begin
    inc_val = '0;
    dec_val = '0;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < int'(NumBcd); i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end else begin
        inc_val[4*i +: 4] = count_q[4*i +: 4];
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end else begin
        dec_val[4*i +: 4] = count_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_clean;
    end else if (tick) begin
      count_d = dir ? inc_val : dec_val;
      wrap_d  = dir ? carry : borrow;
    end
  end

  always_comb begin
    anim_d = anim_q;
    if (step) begin
      anim_d = dir ? {anim_q[4:0], anim_q[5]} : {anim_q[0], anim_q[5:1]};
    end
  end

  always_comb begin
    scan_wrap  = (scan_cnt_q == ScanMax);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
    idx_d      = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
  end

  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank      = '0;
    zero_above = blank_lz;
    for (int i = int'(NumBcd) - 1; i >= 0; i--) begin
      zero_above = zero_above & (count_q[4*i +: 4] == 4'd0);
      blank[i]   = zero_above & (i != 0);
    end
  end

  always_comb begin
    seg_d = {1'b1, anim_q};
    an_d  = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      an_d[i] = (idx_q != IdxW'(i));
    end
    for (int i = 0; i < int'(NumBcd); i++) begin
      if (idx_q == IdxW'(i)) begin
        seg_d = blank[i] ? 7'b1111111 : bcd_to_seg(count_q[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      anim_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      anim_q     <= 6'b111110;
      seg_q      <= 7'b1000000;
      an_q       <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else begin
      tick_cnt_q <= tick_cnt_d;
      anim_cnt_q <= anim_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      anim_q     <= anim_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = 1'b1;
  assign count_bcd = count_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_sevseg_scan_counter.sv
// Scoreboard bench for sevseg_scan_counter: a decimal-arithmetic reference model queues the
// expected registered outputs each cycle; a monitor pops and compares after every edge.
module tb_sevseg_scan_counter;

  logic        clk = 1'b0;
  logic        reset, run, hold, dir, load, blank_lz;
  logic [11:0] load_val;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [11:0] count_bcd;
  logic        wrap;

  sevseg_scan_counter #(
    .NUM_DIGITS(4),
    .TICK_DIV  (4),
    .ANIM_DIV  (2),
    .SCAN_DIV  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .hold     (hold),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .count_bcd(count_bcd),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] cnt;
    logic        wrap;
    logic [6:0]  seg;
    logic [3:0]  an;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // Reference state: counter as a plain decimal number, animation as the lit segment index.
  int m_val, m_tc, m_ac, m_sc, m_idx, m_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int sanitize(input logic [11:0] lv);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 3; i++) begin
      int n = int'(lv[4*i +: 4]);
      if (n > 9) n = 0;
      v += n * w;
      w *= 10;
    end
    return v;
  endfunction

  // Drive one cycle of inputs, queue the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic ru, input logic h, input logic d,
                     input logic l, input logic [11:0] lv, input logic blz);
    exp_t e;
    int   pw;
    bit   act, tk, st;
    reset = r; run = ru; hold = h; dir = d; load = l; load_val = lv; blank_lz = blz;
    e = '0;
    if (r) begin
      m_val = 0; m_tc = 0; m_ac = 0; m_sc = 0; m_idx = 0; m_p = 0;
      e.seg = 7'b1000000;
      e.an  = 4'b1110;
    end else begin
      pw = 1;
      for (int k = 0; k < m_idx; k++) pw *= 10;
      if (m_idx == 3) begin
        e.seg = 7'b1111111;
        e.seg[m_p] = 1'b0;
      end else if (blz && m_idx >= 1 && m_val < pw) begin
        e.seg = 7'b1111111;
      end else begin
        e.seg = seg_of((m_val / pw) % 10);
      end
      e.an = 4'b1111;
      e.an[m_idx] = 1'b0;
      act = ru && !h;
      tk  = act && (m_tc == 3);
      st  = act && (m_ac == 1);
      if (l) begin
        m_val = sanitize(lv);
        m_tc  = 0;
      end else begin
        if (act) m_tc = (m_tc + 1) % 4;
        if (tk) begin
          if (d) begin
            e.wrap = (m_val == 999);
            m_val  = (m_val + 1) % 1000;
          end else begin
            e.wrap = (m_val == 0);
            m_val  = (m_val + 999) % 1000;
          end
        end
      end
      if (act) m_ac = (m_ac + 1) % 2;
      if (st) m_p = d ? (m_p + 1) % 6 : (m_p + 5) % 6;
      if (m_sc == 1) m_idx = (m_idx + 1) % 4;
      m_sc = (m_sc + 1) % 2;
    end
    e.cnt = to_bcd(m_val);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: outputs are registered and presented every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("count_bcd", 32'(count_bcd), 32'(e.cnt));
          chk("wrap", 32'(wrap), 32'(e.wrap));
          chk("seg", 32'(seg), 32'(e.seg));
          chk("an", 32'(an), 32'(e.an));
          chk("dp", 32'(dp), 32'(1'b1));
        end
      end
    end
  end

  initial begin
    logic rblz;
    rblz = 1'b0;
    cyc(1, 0, 0, 1, 0, 12'h000, 0);
    cyc(1, 0, 0, 1, 0, 12'h000, 0);

    // Count up from reset: one increment every 4 cycles.
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 1, 0, 12'h000, 0);
    chk("t1_count", 32'(count_bcd), 32'h004);

    // Wrap up and down.
    cyc(0, 0, 0, 1, 1, 12'h999, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 0, 12'h000, 0);
    chk("t2_wrap_up_count", 32'(count_bcd), 32'h000);
    chk("t2_wrap_up_pulse", 32'(wrap), 32'h1);
    cyc(0, 1, 0, 1, 0, 12'h000, 0);
    chk("t2_wrap_one_cycle", 32'(wrap), 32'h0);
    cyc(0, 0, 0, 0, 1, 12'h000, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 12'h000, 0);
    chk("t2_wrap_dn_count", 32'(count_bcd), 32'h999);
    chk("t2_wrap_dn_pulse", 32'(wrap), 32'h1);

    // Load coinciding with a tick wins and restarts the tick period.
    while (m_tc != 3) cyc(0, 1, 0, 1, 0, 12'h000, 0);
    cyc(0, 1, 0, 1, 1, 12'h1A5, 0);
    chk("t3_load_sanitised", 32'(count_bcd), 32'h105);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, 12'h000, 0);
    chk("t3_no_early_tick", 32'(count_bcd), 32'h105);
    cyc(0, 1, 0, 1, 0, 12'h000, 0);
    chk("t3_next_tick", 32'(count_bcd), 32'h106);

    // Hold freezes both prescalers.
    cyc(0, 1, 0, 0, 0, 12'h000, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 12'h000, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 12'h000, 0);

    // Blanking on and off across a full scan.
    cyc(0, 0, 0, 1, 1, 12'h007, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 12'h000, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 12'h000, 0);

    // Reset on the wrapping tick suppresses the wrap.
    cyc(0, 0, 0, 1, 1, 12'h999, 0);
    while (m_tc != 3) cyc(0, 1, 0, 1, 0, 12'h000, 0);
    cyc(1, 1, 0, 1, 0, 12'h000, 0);
    chk("t6_reset_count", 32'(count_bcd), 32'h000);
    chk("t6_reset_wrap", 32'(wrap), 32'h0);
    chk("t6_reset_an", 32'(an), 32'he);

    // Randomised traffic.
    for (int n = 0; n < 800; n++) begin
      logic rr, ru, rh, rd, rl;
      logic [11:0] rv;
      rr = ($urandom_range(0, 99) == 0);
      ru = ($urandom_range(0, 9) != 0);
      rh = ($urandom_range(0, 5) == 0);
      rd = 1'($urandom_range(0, 1));
      rl = ($urandom_range(0, 19) == 0);
      rv = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 29) == 0) rblz = ~rblz;
      cyc(rr, ru, rh, rd, rl, rv, rblz);
    end

    done = 1'b1;
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
